frame_buffer_reader: RTL and testbench

//  Avalon-MM read master that fetches one 16-bit RGB565 frame from SDRAM and feeds it to the LCD

---
 rtl/frame_buffer_reader.sv | 160 ++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader.sv
// Avalon-MM read master that streams one RGB565 frame from SDRAM into the LCD pixel stream.
// A credit-limited FWFT FIFO absorbs SDRAM latency; wr_lcd starts the controller once prefetched.
module frame_buffer_reader #(
   parameter int ADDR_W       = 32,
   parameter int FRAME_PIXELS = 384000,
   parameter int FIFO_DEPTH   = 64,
   parameter int PREFETCH_LVL = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] frame_base,
   input  logic              frame_sync,
   output logic              wr_lcd,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [15:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [15:0]       dataOut,
   output logic              valid,
   input  logic              ready,
   output logic              frame_done
);

   localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
   localparam int OCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  C_FRAME = CNT_W'(FRAME_PIXELS);
   localparam logic [OCNT_W-1:0] C_PREF  = OCNT_W'(PREFETCH_LVL);
   localparam logic [OCNT_W:0]   C_DEPTH = (OCNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_STREAM,
      S_DONE,
      S_WAITSYNC
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_avm_address;
   logic                r_avm_read;
   logic                r_wr_lcd;
   logic                r_frame_done;
   logic [CNT_W-1:0]    r_req_cnt;
   logic [CNT_W-1:0]    r_pop_cnt;
   logic [OCNT_W-1:0]   r_outstanding;
   logic [OCNT_W-1:0]   r_fifo_count;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [15:0]         r_mem [FIFO_DEPTH];
   logic                r_sync_seen;
   logic [1:0]          r_wait_cnt;

   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_valid;
   logic                w_active;
   logic                w_credit;
   logic                w_issue;
   logic [CNT_W-1:0]    w_req_nxt;
   logic [OCNT_W-1:0]   w_out_nxt;
   logic [OCNT_W-1:0]   w_fifo_nxt;

   // Returns with nothing outstanding are stale (e.g. from before a reset) and dropped.
   assign w_accept   = r_avm_read & ~avm_waitrequest;
   assign w_push     = avm_readdatavalid & (r_outstanding != '0);
   assign w_valid    = (r_fifo_count != '0);
   assign w_pop      = ready & w_valid;
   assign w_req_nxt  = r_req_cnt + CNT_W'(w_accept);
   assign w_out_nxt  = r_outstanding + OCNT_W'(w_accept) - OCNT_W'(w_push);
   assign w_fifo_nxt = r_fifo_count + OCNT_W'(w_push) - OCNT_W'(w_pop);
   assign w_active   = (r_state == S_PREFETCH) || (r_state == S_STREAM);
   assign w_credit   = (({1'b0, w_out_nxt} + {1'b0, w_fifo_nxt}) < C_DEPTH);
   assign w_issue    = w_active && (w_req_nxt < C_FRAME) && w_credit;

   assign avm_read    = r_avm_read;
   assign avm_address = r_avm_address;
   assign wr_lcd      = r_wr_lcd;
   assign frame_done  = r_frame_done;
   assign valid       = w_valid;
   assign dataOut     = w_valid ? r_mem[r_rd_ptr] : 16'h0000;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= avm_readdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_base        <= '0;
         r_avm_address <= '0;
         r_avm_read    <= 1'b0;
         r_wr_lcd      <= 1'b0;
         r_frame_done  <= 1'b0;
         r_req_cnt     <= '0;
         r_pop_cnt     <= '0;
         r_outstanding <= '0;
         r_fifo_count  <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_sync_seen   <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         r_wr_lcd      <= 1'b0;
         r_frame_done  <= 1'b0;
         r_outstanding <= w_out_nxt;
         r_fifo_count  <= w_fifo_nxt;
         r_req_cnt     <= w_req_nxt;
         r_pop_cnt     <= r_pop_cnt + CNT_W'(w_pop);
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         // A stalled request keeps its address; otherwise the next one is decided here.
         if (!(r_avm_read && avm_waitrequest)) begin
            r_avm_read <= w_issue;
            if (w_issue) r_avm_address <= r_base + (ADDR_W'(w_req_nxt) << 1);
         end

         case (r_state)
            S_IDLE: begin
               if (enable && frame_sync) begin
                  r_base    <= frame_base;
                  r_req_cnt <= '0;
                  r_pop_cnt <= '0;
                  r_state   <= S_PREFETCH;
               end
            end
            S_PREFETCH: begin
               if ((r_fifo_count >= C_PREF) || (r_req_cnt == C_FRAME)) begin
                  r_wr_lcd <= 1'b1;
                  r_state  <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (r_pop_cnt == C_FRAME) begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DONE: begin
               r_sync_seen <= 1'b0;
               r_wait_cnt  <= '0;
               r_state     <= S_WAITSYNC;
            end
            S_WAITSYNC: begin
               // Arm after seeing the controller busy (or a short timeout), then wait for idle.
               if (!frame_sync) r_sync_seen <= 1'b1;
               if (r_wait_cnt != 2'd2) r_wait_cnt <= r_wait_cnt + 2'd1;
               if ((r_sync_seen || (r_wait_cnt == 2'd2)) && frame_sync) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader: latency-1 SDRAM slave, LCD consumer model,
// expected addresses/pixels queued per frame and checked by an independent negedge monitor.
module tb_frame_buffer_reader;

   localparam int FP = 8;
   localparam int FD = 4;
   localparam int PL = 2;

   logic        clk, rst, enable, frame_sync, wr_lcd, avm_read, avm_waitrequest;
   logic        avm_readdatavalid, valid, ready, frame_done;
   logic [31:0] frame_base, avm_address;
   logic [15:0] avm_readdata, dataOut;

   frame_buffer_reader #(
      .ADDR_W(32), .FRAME_PIXELS(FP), .FIFO_DEPTH(FD), .PREFETCH_LVL(PL)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
      .frame_sync(frame_sync), .wr_lcd(wr_lcd), .avm_address(avm_address),
      .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .dataOut(dataOut), .valid(valid), .ready(ready), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total, bad;
   logic [31:0] exp_addr_q[$];
   logic [15:0] exp_pix_q[$];
   int          acc_cnt, pop_cnt, push_cnt, wr_cnt, done_cnt, done_age;
   int          stall_at, stall_left, ready_block;
   logic        rand_stall, rand_ready, sync_block, gate_check, inject_stale;
   logic        last_acc, rdv_real, prev_stall, prev_vnr;
   logic [31:0] last_addr, prev_addr;
   logic [15:0] prev_data, salt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [15:0] memfn(input logic [31:0] a);
      return (a[16:1] * 16'd40503) ^ a[31:16] ^ salt;
   endfunction

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   // SDRAM slave (one-cycle read latency) and LCD controller model.
   always @(posedge clk) begin
      #2;
      if (last_acc) begin
         avm_readdatavalid = 1'b1; avm_readdata = memfn(last_addr); rdv_real = 1'b1;
      end else if (inject_stale) begin
         avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD; rdv_real = 1'b0; inject_stale = 1'b0;
      end else begin
         avm_readdatavalid = 1'b0; avm_readdata = 16'($urandom); rdv_real = 1'b0;
      end
      if (stall_left > 0) begin
         avm_waitrequest = 1'b1; stall_left--;
      end else if (stall_at >= 0 && avm_read && acc_cnt == stall_at) begin
         avm_waitrequest = 1'b1; stall_left = 4; stall_at = -1;
      end else begin
         avm_waitrequest = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (wr_cnt == 0) ready = 1'b0;
      else if (ready_block > 0) begin ready = 1'b0; ready_block--; end
      else ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != 0) done_age++;
      frame_sync = !sync_block && !(wr_cnt != 0 && done_age < 3);
   end

   // Monitor: sees exactly the values the next rising edge acts on.
   always @(negedge clk) begin
      if (rst) begin
         last_acc = 1'b0; prev_stall = 1'b0; prev_vnr = 1'b0;
      end else begin
         chk("inflight_le_depth", 32'((acc_cnt - pop_cnt) <= FD), 32'd1);
         if (prev_stall) begin
            chk("stall_hold_read", 32'(avm_read), 32'd1);
            chk("stall_hold_addr", avm_address, prev_addr);
         end
         if (prev_vnr) begin
            chk("bp_hold_valid", 32'(valid), 32'd1);
            chk("bp_hold_data", 32'(dataOut), 32'(prev_data));
         end
         if (wr_lcd) begin
            wr_cnt++;
            chk("wr_lcd_prefetch_level", 32'(push_cnt >= PL || acc_cnt == FP), 32'd1);
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_pixel_count", 32'(pop_cnt), 32'(FP));
            chk("done_queues_empty", 32'(exp_pix_q.size() + exp_addr_q.size()), 32'd0);
         end
         if (gate_check) chk("gated_no_read", 32'(avm_read), 32'd0);
         if (avm_read && !avm_waitrequest) begin
            chk("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("read_addr", avm_address, exp_addr_q.pop_front());
            last_acc = 1'b1; last_addr = avm_address; acc_cnt++;
         end else begin
            last_acc = 1'b0;
         end
         if (avm_readdatavalid && rdv_real) push_cnt++;
         if (valid && ready) begin
            chk("pixel_expected", 32'(exp_pix_q.size() != 0), 32'd1);
            if (exp_pix_q.size() != 0) chk("pixel_data", 32'(dataOut), 32'(exp_pix_q.pop_front()));
            pop_cnt++;
         end
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
         prev_vnr   = valid && !ready;
         prev_data  = dataOut;
      end
   end

   task automatic check_outputs_zero(input string nm);
      chk({nm, "_avm_read"}, 32'(avm_read), 32'd0);
      chk({nm, "_avm_address"}, avm_address, 32'd0);
      chk({nm, "_wr_lcd"}, 32'(wr_lcd), 32'd0);
      chk({nm, "_valid"}, 32'(valid), 32'd0);
      chk({nm, "_dataOut"}, 32'(dataOut), 32'd0);
      chk({nm, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   task automatic start_frame(input logic [31:0] base);
      int n;
      logic [31:0] a;
      exp_addr_q.delete();
      exp_pix_q.delete();
      for (int i = 0; i < FP; i++) begin
         a = base + 32'(2 * i);
         exp_addr_q.push_back(a);
         exp_pix_q.push_back(memfn(a));
      end
      acc_cnt = 0; pop_cnt = 0; push_cnt = 0; wr_cnt = 0; done_cnt = 0; done_age = 0;
      frame_base = base;
      enable = 1'b1;
      n = 0;
      while (!avm_read && n < 50) begin step(); n++; end
      chk("frame_started", 32'(avm_read), 32'd1);
      enable = 1'b0;
      frame_base = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt == 0 && n < 500) begin step(); n++; end
      chk("frame_done_seen", 32'(done_cnt != 0), 32'd1);
      repeat (8) step();
      chk("wr_lcd_once", 32'(wr_cnt), 32'd1);
      chk("frame_done_once", 32'(done_cnt), 32'd1);
      chk("frame_pixels", 32'(pop_cnt), 32'(FP));
   endtask

   task automatic run_frame(input logic [31:0] base);
      start_frame(base);
      wait_done();
   endtask

   initial begin
      int n;
      total = 0; bad = 0;
      rst = 1'b1; enable = 1'b0; frame_base = '0; frame_sync = 1'b1;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; ready = 1'b0;
      acc_cnt = 0; pop_cnt = 0; push_cnt = 0; wr_cnt = 0; done_cnt = 0; done_age = 0;
      stall_at = -1; stall_left = 0; ready_block = 0;
      rand_stall = 1'b0; rand_ready = 1'b0; sync_block = 1'b0; gate_check = 1'b0;
      inject_stale = 1'b0; last_acc = 1'b0; rdv_real = 1'b0; prev_stall = 1'b0; prev_vnr = 1'b0;
      last_addr = '0; prev_addr = '0; prev_data = '0;
      salt = 16'($urandom);

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      step();
      rst = 1'b0;
      step();

      // Basic frame, then a frame with a 5-cycle stall on the third read.
      run_frame(32'h0000_1000);
      stall_at = 2;
      start_frame(32'h0000_1000);
      n = 0;
      while (!(avm_read && avm_waitrequest) && n < 50) begin step(); n++; end
      chk("stall_addr", avm_address, 32'h0000_1004);
      wait_done();

      // LCD backpressure, then address wrap.
      ready_block = 20;
      run_frame(32'h0004_2000);
      run_frame(32'hFFFF_FFFC);

      // Reset mid-stream, stale return while idle, then a fresh frame from pixel 0.
      start_frame(32'h0000_5000);
      n = 0;
      while (wr_cnt == 0 && n < 100) begin step(); n++; end
      chk("midrst_stream_reached", 32'(wr_cnt), 32'd1);
      repeat (2) step();
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("midrst");
      step();
      step();
      rst = 1'b0;
      exp_addr_q.delete();
      exp_pix_q.delete();
      inject_stale = 1'b1;
      step();
      run_frame(32'h0000_6000);

      // Controller stays busy after frame_done: no new frame, then enable drops.
      start_frame(32'h0000_7000);
      n = 0;
      while (wr_cnt == 0 && n < 100) begin step(); n++; end
      sync_block = 1'b1;
      n = 0;
      while (done_cnt == 0 && n < 500) begin step(); n++; end
      chk("gate_frame_done_seen", 32'(done_cnt), 32'd1);
      repeat (4) step();
      enable = 1'b1;
      gate_check = 1'b1;
      repeat (20) step();
      enable = 1'b0;
      sync_block = 1'b0;
      repeat (20) step();
      gate_check = 1'b0;
      chk("gate_no_extra_done", 32'(done_cnt), 32'd1);
      run_frame(32'h0000_8000);

      // Randomized frames: random bases, stalls and LCD ready pattern.
      for (int k = 0; k < 6; k++) begin
         rand_stall  = 1'($urandom_range(0, 1));
         rand_ready  = 1'b1;
         ready_block = ($urandom_range(0, 1) != 0) ? int'($urandom_range(5, 15)) : 0;
         run_frame($urandom & 32'hFFFF_FFFE);
      end
      rand_stall = 1'b0;
      rand_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
